// File: rtl/fft_pkg.sv
// Shared types and defaults for the FFT peak finder.
package fft_pkg;

  localparam int unsigned FFT_FRAMESIZE = 1024;
  localparam int unsigned BIN_W         = $clog2(FFT_FRAMESIZE);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    FLUSH  = 2'd2,
    REPORT = 2'd3
  } peak_state_t;

endpackage

// File: rtl/fft_peak_finder_mag_sq.sv
// Two-stage re^2 + im^2 pipeline; a valid bit and the bin index ride alongside.
module mag_sq #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned BW     = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       beat_valid,
  input  logic [BW-1:0]              beat_bin,
  input  logic signed [DATA_W-1:0]   re,
  input  logic signed [DATA_W-1:0]   im,
  output logic                       mag_valid,
  output logic [BW-1:0]              mag_bin,
  output logic [2*DATA_W-1:0]        mag
);

  logic signed [2*DATA_W-1:0] re_w, im_w;
  logic signed [2*DATA_W-1:0] re_sq, im_sq;
  logic                       s1_valid;
  logic [BW-1:0]              s1_bin;

  assign re_w = {{DATA_W{re[DATA_W-1]}}, re};
  assign im_w = {{DATA_W{im[DATA_W-1]}}, im};

  // Each square is at most 2^(2*DATA_W-2), so the unsigned sum cannot wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_bin    <= '0;
      re_sq     <= '0;
      im_sq     <= '0;
      mag_valid <= 1'b0;
      mag_bin   <= '0;
      mag       <= '0;
    end else begin
      s1_valid  <= beat_valid;
      s1_bin    <= beat_bin;
      re_sq     <= re_w * re_w;
      im_sq     <= im_w * im_w;
      mag_valid <= s1_valid;
      mag_bin   <= s1_bin;
      mag       <= unsigned'(re_sq) + unsigned'(im_sq);
    end
  end

endmodule

// File: rtl/fft_peak_finder.sv
// Finds the strongest positive-frequency bin of each FFT output frame.
// Optional tlast-based framing and length check: define FFT_FRAME_CHECK_EN.
module fft_peak_finder
  import fft_pkg::*;
#(
  parameter int unsigned FRAMESIZE = FFT_FRAMESIZE,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned MIN_BIN   = 1
) (
  input  logic                          clk_100mhz,
  input  logic                          rst,
  input  logic [2*DATA_W-1:0]           fft_tdata,
  input  logic                          fft_tvalid,
  input  logic                          fft_tlast,
  output logic                          fft_tready,
  output logic [$clog2(FRAMESIZE)-1:0]  peak_bin,
  output logic [2*DATA_W-1:0]           peak_mag,
  output logic                          peak_valid,
  output logic                          frame_err,
  output logic [1:0]                    state
);

  localparam int unsigned BW   = $clog2(FRAMESIZE);
  localparam int unsigned HALF = FRAMESIZE / 2;

  peak_state_t          st, st_next;
  logic                 flush_done;
  logic [BW-1:0]        bin_cnt;
  logic                 accept, cnt_end, frame_end, err_flag;
  logic                 mag_valid;
  logic [BW-1:0]        mag_bin;
  logic [2*DATA_W-1:0]  mag;
  logic [BW-1:0]        max_bin;
  logic [2*DATA_W-1:0]  max_mag;

  assign fft_tready = ~rst & ((st == IDLE) | (st == ACCUM));
  assign accept     = fft_tvalid & fft_tready;
  assign cnt_end    = (bin_cnt == BW'(FRAMESIZE - 1));
  assign state      = st;

`ifdef FFT_FRAME_CHECK_EN
  assign frame_end = accept & (fft_tlast | cnt_end);

  always_ff @(posedge clk_100mhz) begin
    if (rst)
      err_flag <= 1'b0;
    else if (frame_end)
      err_flag <= fft_tlast ^ cnt_end;
  end
`else
  logic unused_tlast;
  assign unused_tlast = fft_tlast;
  assign frame_end    = accept & cnt_end;
  assign err_flag     = 1'b0;
`endif

  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      st         <= IDLE;
      flush_done <= 1'b0;
    end else begin
      st         <= st_next;
      flush_done <= (st == FLUSH) & ~flush_done;
    end
  end

  always_comb begin
    st_next = st;
    unique case (st)
      IDLE:    if (accept) st_next = frame_end ? FLUSH : ACCUM;
      ACCUM:   if (frame_end) st_next = FLUSH;
      FLUSH:   if (flush_done) st_next = REPORT;
      REPORT:  st_next = IDLE;
      default: st_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_100mhz) begin
    if (rst || frame_end)
      bin_cnt <= '0;
    else if (accept)
      bin_cnt <= bin_cnt + 1'b1;
  end

  mag_sq #(
    .DATA_W (DATA_W),
    .BW     (BW)
  ) u_mag_sq (
    .clk        (clk_100mhz),
    .rst        (rst),
    .beat_valid (accept),
    .beat_bin   (bin_cnt),
    .re         (fft_tdata[DATA_W-1:0]),
    .im         (fft_tdata[2*DATA_W-1:DATA_W]),
    .mag_valid  (mag_valid),
    .mag_bin    (mag_bin),
    .mag        (mag)
  );

  // Strict greater-than keeps the lowest bin on ties.
  always_ff @(posedge clk_100mhz) begin
    if (rst || st == REPORT) begin
      max_mag <= '0;
      max_bin <= BW'(MIN_BIN);
    end else if (mag_valid && mag_bin >= BW'(MIN_BIN) && mag_bin < BW'(HALF)
                 && mag > max_mag) begin
      max_mag <= mag;
      max_bin <= mag_bin;
    end
  end

  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      peak_bin   <= '0;
      peak_mag   <= '0;
      peak_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      peak_valid <= (st == REPORT);
      frame_err  <= (st == REPORT) & err_flag;
      if (st == REPORT) begin
        peak_bin <= max_bin;
        peak_mag <= max_mag;
      end
    end
  end

endmodule

// File: doc/fft_peak_finder.md
# fft_peak_finder

Consumer end of the FFT AXI-stream: accepts complex FFT output frames, computes per-bin magnitude squared, and reports the strongest bin in the positive-frequency half. Sits between the FFT core's master output and the autotuner pitch logic, mirroring the windowing FSM that feeds the FFT's slave input.

## Interface

- `FRAMESIZE`, 1024: bins per frame; power of two, at least 8.
- `DATA_W`, 16: width of each signed real/imag component.
- `MIN_BIN`, 1: lowest bin considered, so the DC bin is skipped by default.

- `clk_100mhz`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `fft_tdata`  in  2*DATA_W  {im, re}, both signed two's complement.
- `fft_tvalid`  in  1  beat valid.
- `fft_tlast`  in  1  last beat of frame.
- `fft_tready`  out  1  beat accept.
- `peak_bin`  out  $clog2(FRAMESIZE)  index of the maximum bin.
- `peak_mag`  out  2*DATA_W  unsigned re²+im² of the maximum bin.
- `peak_valid`  out  1  one-cycle result strobe.
- `frame_err`  out  1  frame length mismatch; qualified by `peak_valid`.
- `state`  out  2  debug view of the FSM state.

## Operation

- A beat is accepted on a clock edge where `fft_tvalid & fft_tready`. Nothing else advances the bin counter.
- States: IDLE=0, ACCUM=1, FLUSH=2, REPORT=3.
  - IDLE to ACCUM on the first accepted beat.
  - ACCUM to FLUSH on the frame-end beat.
  - FLUSH holds for 2 cycles, then goes to REPORT.
  - REPORT lasts 1 cycle, then goes to IDLE.
- `fft_tready` = 1 in IDLE and ACCUM, 0 in FLUSH and REPORT.
- The bin counter starts at 0 and increments per accepted beat. It clears on frame end and on reset.
- `mag_sq` is a 2-stage pipeline:
  - stage 1 registers re² and im² as signed products;
  - stage 2 registers their unsigned sum, which is 2*DATA_W bits wide.
  - The bin index travels alongside. (-2^(DATA_W-1))² summed twice fits exactly, so there is no overflow and no saturation.
- Only bins MIN_BIN through FRAMESIZE/2-1 are compared.
  - The update rule is strictly greater-than, so on a tie the lowest bin wins.
  - The running maximum initialises to mag 0, bin MIN_BIN at frame start.
- In REPORT: `peak_bin`/`peak_mag` load from the running maximum, `peak_valid`=1, and the running maximum clears.
  - `peak_bin` and `peak_mag` hold until the next REPORT.
- An all-zero frame reports bin MIN_BIN with mag 0.

## Timing

- Last beat accepted at edge N:
  - FLUSH occupies cycles N+1 and N+2;
  - `peak_valid` is high for the cycle after edge N+3;
  - `fft_tready` is low for exactly 3 cycles and returns high after edge N+3.
- Arbitrary `fft_tvalid` gaps change nothing except timing.
- Reset values:
  - `fft_tready`=0 while `rst` is high, 1 on the first cycle after;
  - `peak_bin`=0, `peak_mag`=0, `peak_valid`=0, `frame_err`=0, `state`=IDLE.
- Reset mid-frame or in FLUSH discards the partial frame: no `peak_valid`, and the pipeline is cleared.
- Beats with bin ≥ FRAMESIZE/2 are accepted (`fft_tready` stays 1) but are not compared.

## Configuration

- `FFT_FRAME_CHECK_EN` defined:
  - frame end is the accepted beat with `fft_tlast`=1 or the beat with counter == FRAMESIZE-1, whichever comes first;
  - `frame_err`=1 in the REPORT cycle when those two conditions did not coincide;
  - `frame_err` is 0 in every other cycle.
- Not defined:
  - `fft_tlast` is ignored;
  - frame end is counter == FRAMESIZE-1 only;
  - `frame_err` is tied to 0.

## Structure

- Package `fft_pkg` holds:
  - the `peak_state_t` enum (IDLE/ACCUM/FLUSH/REPORT);
  - the `FFT_FRAMESIZE` default;
  - `BIN_W = $clog2(FFT_FRAMESIZE)`.
- One sub-module, `mag_sq`: the 2-stage re²+im² pipeline, carrying a valid bit and the bin index.

## Test plan (FRAMESIZE=32, DATA_W=16, continuous tvalid unless stated)

1. Bin 5 re=1000, im=0, all other bins 0 → `peak_bin`=5, `peak_mag`=1000000, `peak_valid` one cycle after edge N+3, `fft_tready` low for 3 cycles.
2. Bins 3 and 7 both re=-300, im=400 → `peak_bin`=3, `peak_mag`=250000.
3. Bin 0 re=30000, bin 20 re=20000, bin 9 re=100 → `peak_bin`=9, `peak_mag`=10000.
4. Bin 12 re=im=-32768 → `peak_mag`=2147483648 with no wrap.
5. Same frame as test 1 with random tvalid gaps, two frames back to back → two identical reports.
6. `rst` pulsed at beat 10, then a clean frame → no `peak_valid` for the aborted frame; the clean frame reports correctly.
7. `FFT_FRAME_CHECK_EN` defined, `fft_tlast` on beat 20 → report after 21 beats with `frame_err`=1; the next frame with tlast on beat 31 reports `frame_err`=0.
